// File: rtl/sprite_motion_engine_if.sv
// Load port for the sprite motion engine: a valid/ready handshake that carries a new
// position and velocity from the game logic to the engine.
interface sprite_motion_engine_if #(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned VEL_W   = 5
);
  logic               load_valid;
  logic               load_ready;
  logic [COORD_W-1:0] load_x;
  logic [COORD_W-1:0] load_y;
  logic [VEL_W-1:0]   load_vx;
  logic [VEL_W-1:0]   load_vy;

  // Game logic side.
  modport master (
    output load_valid, load_x, load_y, load_vx, load_vy,
    input  load_ready
  );

  // Engine side.
  modport slave (
    input  load_valid, load_x, load_y, load_vx, load_vy,
    output load_ready
  );
endinterface

// File: rtl/sprite_motion_engine.sv
// Per-sprite position/velocity engine. Each accepted frame tick runs
// IDLE -> CALC -> COMMIT -> IDLE and applies a bounce, wrap or stop edge policy per axis.
module sprite_motion_engine #(
  parameter int unsigned COORD_W  = 8,
  parameter int unsigned VEL_W    = 5,
  parameter int unsigned SIZE_W   = 7,
  parameter int unsigned SCREEN_W = 128,
  parameter int unsigned SCREEN_H = 96,
  parameter int unsigned INIT_X   = 0,
  parameter int unsigned INIT_Y   = 0,
  parameter int          INIT_VX  = 1,
  parameter int          INIT_VY  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step_i,
  input  logic                freeze_i,
  input  logic [1:0]          mode_i,
  input  logic [SIZE_W-1:0]   spr_w_i,
  input  logic [SIZE_W-1:0]   spr_h_i,
  sprite_motion_engine_if.slave load_io,
  output logic [COORD_W-1:0]  x_pos_o,
  output logic [COORD_W-1:0]  y_pos_o,
  output logic [VEL_W-1:0]    x_vel_o,
  output logic [VEL_W-1:0]    y_vel_o,
  output logic                hit_x_o,
  output logic                hit_y_o,
  output logic                step_drop_o
);

  // Two extra bits: one for the sign, one so pos + vel can never overflow.
  localparam int unsigned CW = COORD_W + 2;

  localparam logic [COORD_W-1:0] InitX  = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] InitY  = COORD_W'(INIT_Y);
  localparam logic [VEL_W-1:0]   InitVx = VEL_W'(INIT_VX);
  localparam logic [VEL_W-1:0]   InitVy = VEL_W'(INIT_VY);

  typedef logic signed [CW-1:0]    calc_t;
  typedef logic signed [VEL_W-1:0] vel_t;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    logic [VEL_W-1:0]   vel;
    logic               hit;
  } axis_t;

  typedef enum logic [1:0] {StIdle, StCalc, StCommit} state_e;

  state_e state_q, state_d;

  logic [COORD_W-1:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic [VEL_W-1:0]   x_vel_q, x_vel_d, y_vel_q, y_vel_d;
  logic               hit_x_q, hit_x_d, hit_y_q, hit_y_d;
  logic               step_drop_q, step_drop_d;
  calc_t              nx_q, nx_d, ny_q, ny_d;
  calc_t              xlim_q, xlim_d, ylim_q, ylim_d;
  logic [1:0]         mode_q, mode_d;

  logic  take_load, calc_en, commit_en;
  axis_t ax, ay;

  // Negation that saturates the most-negative velocity to the most-positive one.
  function automatic vel_t neg_sat(vel_t v);
    vel_t vmin;
    vmin = {1'b1, {(VEL_W-1){1'b0}}};
    if (v == vmin) return {1'b0, {(VEL_W-1){1'b1}}};
    return -v;
  endfunction

  // Highest legal position for a sprite of size sz; zero when the sprite exceeds the screen.
  function automatic calc_t limit(int unsigned screen, logic [SIZE_W-1:0] sz);
    if (32'(sz) >= screen) return '0;
    return calc_t'(screen - 32'(sz));
  endfunction

  // Edge policy for one axis given the unclamped next position n.
  function automatic axis_t apply_edge(calc_t n, calc_t lim, vel_t vel, logic [1:0] mode,
                                       int unsigned screen);
    axis_t r;
    calc_t scr;
    calc_t w;
    scr   = calc_t'(screen);
    w     = n;
    r.pos = n[COORD_W-1:0];
    r.vel = vel;
    r.hit = 1'b0;
    case (mode)
      2'd1: begin
        if (n < 0) begin
          w     = n + scr;
          r.hit = 1'b1;
        end else if (n >= scr) begin
          w     = n - scr;
          r.hit = 1'b1;
        end
        r.pos = w[COORD_W-1:0];
      end
      2'd2: begin
        if (n < 0) begin
          r.pos = '0;
          r.vel = '0;
          r.hit = 1'b1;
        end else if (n > lim) begin
          r.pos = lim[COORD_W-1:0];
          r.vel = '0;
          r.hit = 1'b1;
        end
      end
      default: begin
        // Bounce (mode 0 and reserved 3): touching an edge while heading into it also counts.
        if (n < 0 || (n == 0 && vel < 0)) begin
          r.pos = '0;
          if (vel < 0) r.vel = neg_sat(vel);
          r.hit = 1'b1;
        end else if (n > lim || (n == lim && vel > 0)) begin
          r.pos = lim[COORD_W-1:0];
          if (vel > 0) r.vel = neg_sat(vel);
          r.hit = 1'b1;
        end
      end
    endcase
    return r;
  endfunction

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state: a load in IDLE wins over a step, so only a lone unfrozen step starts an update.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (step_i && !freeze_i && !load_io.load_valid) state_d = StCalc;
      StCalc:   state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs and control strobes.
  always_comb begin
    load_io.load_ready = (state_q == StIdle);
    take_load          = (state_q == StIdle) && load_io.load_valid;
    calc_en            = (state_q == StCalc);
    commit_en          = (state_q == StCommit);
    // Frozen steps vanish silently; otherwise a step that cannot start an update is reported.
    step_drop_d        = step_i && !freeze_i && ((state_q != StIdle) || load_io.load_valid);
  end

  // CALC datapath: unclamped next positions, per-axis limits and the sampled mode.
  always_comb begin
    nx_d   = nx_q;
    ny_d   = ny_q;
    xlim_d = xlim_q;
    ylim_d = ylim_q;
    mode_d = mode_q;
    if (calc_en) begin
      nx_d   = calc_t'({2'b00, x_pos_q}) + calc_t'(vel_t'(x_vel_q));
      ny_d   = calc_t'({2'b00, y_pos_q}) + calc_t'(vel_t'(y_vel_q));
      xlim_d = limit(SCREEN_W, spr_w_i);
      ylim_d = limit(SCREEN_H, spr_h_i);
      mode_d = mode_i;
    end
  end

  // Edge policy evaluated on the registered CALC results.
  always_comb begin
    ax = apply_edge(nx_q, xlim_q, vel_t'(x_vel_q), mode_q, SCREEN_W);
    ay = apply_edge(ny_q, ylim_q, vel_t'(y_vel_q), mode_q, SCREEN_H);
  end

  // Architectural state next values: load or commit; hit pulses last one cycle.
  always_comb begin
    x_pos_d = x_pos_q;
    y_pos_d = y_pos_q;
    x_vel_d = x_vel_q;
    y_vel_d = y_vel_q;
    hit_x_d = 1'b0;
    hit_y_d = 1'b0;
    if (take_load) begin
      x_pos_d = load_io.load_x;
      y_pos_d = load_io.load_y;
      x_vel_d = load_io.load_vx;
      y_vel_d = load_io.load_vy;
    end else if (commit_en) begin
      x_pos_d = ax.pos;
      y_pos_d = ay.pos;
      x_vel_d = ax.vel;
      y_vel_d = ay.vel;
      hit_x_d = ax.hit;
      hit_y_d = ay.hit;
    end
  end

  // Datapath registers; reset drops any in-flight update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_pos_q     <= InitX;
      y_pos_q     <= InitY;
      x_vel_q     <= InitVx;
      y_vel_q     <= InitVy;
      hit_x_q     <= 1'b0;
      hit_y_q     <= 1'b0;
      step_drop_q <= 1'b0;
      nx_q        <= '0;
      ny_q        <= '0;
      xlim_q      <= '0;
      ylim_q      <= '0;
      mode_q      <= '0;
    end else begin
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      x_vel_q     <= x_vel_d;
      y_vel_q     <= y_vel_d;
      hit_x_q     <= hit_x_d;
      hit_y_q     <= hit_y_d;
      step_drop_q <= step_drop_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      xlim_q      <= xlim_d;
      ylim_q      <= ylim_d;
      mode_q      <= mode_d;
    end
  end

  assign x_pos_o     = x_pos_q;
  assign y_pos_o     = y_pos_q;
  assign x_vel_o     = x_vel_q;
  assign y_vel_o     = y_vel_q;
  assign hit_x_o     = hit_x_q;
  assign hit_y_o     = hit_y_q;
  assign step_drop_o = step_drop_q;

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Directed bench for sprite_motion_engine: inputs change on the falling edge,
// outputs are checked on the falling edge after the relevant rising edge.
module tb_sprite_motion_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       step, freeze;
  logic [1:0] mode;
  logic [6:0] spr_w, spr_h;
  logic [7:0] x_pos, y_pos;
  logic [4:0] x_vel, y_vel;
  logic       hit_x, hit_y, step_drop;

  int errors = 0;
  int checks = 0;

  sprite_motion_engine_if #(.COORD_W(8), .VEL_W(5)) load_if ();

  sprite_motion_engine #(
    .COORD_W (8),
    .VEL_W   (5),
    .SIZE_W  (7),
    .SCREEN_W(128),
    .SCREEN_H(96),
    .INIT_X  (10),
    .INIT_Y  (10),
    .INIT_VX (1),
    .INIT_VY (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .step_i     (step),
    .freeze_i   (freeze),
    .mode_i     (mode),
    .spr_w_i    (spr_w),
    .spr_h_i    (spr_h),
    .load_io    (load_if),
    .x_pos_o    (x_pos),
    .y_pos_o    (y_pos),
    .x_vel_o    (x_vel),
    .y_vel_o    (y_vel),
    .hit_x_o    (hit_x),
    .hit_y_o    (hit_y),
    .step_drop_o(step_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step pulse, then wait until the commit edge has passed (3 edges after the sample).
  task automatic do_step();
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] x, input logic [7:0] y,
                         input logic [4:0] vx, input logic [4:0] vy);
    @(negedge clk);
    load_if.load_valid = 1'b1;
    load_if.load_x     = x;
    load_if.load_y     = y;
    load_if.load_vx    = vx;
    load_if.load_vy    = vy;
    @(negedge clk);
    load_if.load_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    step = 1'b0;
    freeze = 1'b0;
    mode = 2'd0;
    spr_w = 7'd8;
    spr_h = 7'd8;
    load_if.load_valid = 1'b0;
    load_if.load_x = '0;
    load_if.load_y = '0;
    load_if.load_vx = '0;
    load_if.load_vy = '0;

    // Reset state
    #12;
    check("rst_x", x_pos, 10);
    check("rst_y", y_pos, 10);
    check("rst_vx", x_vel, 1);
    check("rst_vy", y_vel, 1);
    check("rst_ready", load_if.load_ready, 1);
    check("rst_pulses", {hit_x, hit_y, step_drop}, 0);
    @(negedge clk) reset = 1'b0;

    // Five plain steps in bounce mode
    repeat (5) do_step();
    check("walk_x", x_pos, 15);
    check("walk_y", y_pos, 15);
    check("walk_hit", {hit_x, hit_y}, 0);

    // Bounce off the right edge: 118+3=121 > 128-8 -> 120, vx=-3
    do_load(8'd118, 8'd40, 5'h03, 5'h00);
    check("load_x", x_pos, 118);
    do_step();
    check("bounce_x", x_pos, 120);
    check("bounce_vx", x_vel, 5'h1d);
    check("bounce_hit", {hit_x, hit_y}, 2'b10);
    @(negedge clk);
    check("bounce_hit_pulse", hit_x, 0);

    // Wrap both directions
    mode = 2'd1;
    do_load(8'd126, 8'd40, 5'h04, 5'h00);
    do_step();
    check("wrap_hi_x", x_pos, 2);
    check("wrap_hi_vx", x_vel, 5'h04);
    check("wrap_hi_hit", hit_x, 1);
    do_load(8'd1, 8'd40, 5'h1d, 5'h00);
    do_step();
    check("wrap_lo_x", x_pos, 126);
    check("wrap_lo_hit", hit_x, 1);

    // Stop at the top edge, then stay quiet
    mode = 2'd2;
    do_load(8'd50, 8'd2, 5'h00, 5'h1b);
    do_step();
    check("stop_y", y_pos, 0);
    check("stop_vy", y_vel, 0);
    check("stop_hit", {hit_x, hit_y}, 2'b01);
    do_step();
    check("stop2_y", y_pos, 0);
    check("stop2_hit", hit_y, 0);

    // Most-negative velocity bounce saturates to +15
    mode = 2'd0;
    do_load(8'd5, 8'd40, 5'h10, 5'h00);
    do_step();
    check("sat_x", x_pos, 0);
    check("sat_vx", x_vel, 5'h0f);
    check("sat_hit", hit_x, 1);

    // Sprite taller than screen: limit floors to 0
    spr_h = 7'd100;
    do_load(8'd50, 8'd0, 5'h00, 5'h02);
    do_step();
    check("big_y", y_pos, 0);
    check("big_vy", y_vel, 5'h1e);
    check("big_hit", hit_y, 1);
    spr_h = 7'd8;

    // Load and step in the same cycle: load wins, step dropped
    @(negedge clk);
    load_if.load_valid = 1'b1;
    load_if.load_x = 8'd20;
    load_if.load_y = 8'd30;
    load_if.load_vx = 5'h01;
    load_if.load_vy = 5'h01;
    step = 1'b1;
    @(negedge clk);
    load_if.load_valid = 1'b0;
    step = 1'b0;
    check("ls_x", x_pos, 20);
    check("ls_y", y_pos, 30);
    check("ls_drop", step_drop, 1);
    repeat (3) @(negedge clk);
    check("ls_nomove", x_pos, 20);

    // Frozen step is ignored silently
    freeze = 1'b1;
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    check("frz_drop", step_drop, 0);
    repeat (2) @(negedge clk);
    check("frz_x", x_pos, 20);
    freeze = 1'b0;

    // Second step while busy is dropped; only one update happens
    @(negedge clk) step = 1'b1;
    @(negedge clk);
    check("busy_ready", load_if.load_ready, 0);
    @(negedge clk) step = 1'b0;
    check("busy_drop", step_drop, 1);
    @(negedge clk);
    check("busy_x", x_pos, 21);
    check("busy_y", y_pos, 31);

    // Reset during CALC aborts the update
    @(negedge clk) step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_x", x_pos, 10);
    check("abort_y", y_pos, 10);
    check("abort_ready", load_if.load_ready, 1);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_hold_x", x_pos, 10);
    check("abort_hit", {hit_x, hit_y}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
